// File: rtl/decode_issue_queue.sv
// Decode/issue queue: DEPTH-entry instruction FIFO with head operand forwarding,
// load-use stall, head branch/jump resolution and MIPS delay-slot handling.
module decode_issue_queue #(
  parameter int DEPTH = 4,
  parameter int N_FWD = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instr,
  output logic [4:0]           ra1,
  output logic [4:0]           ra2,
  input  logic [31:0]          rd1,
  input  logic [31:0]          rd2,
  input  logic [N_FWD-1:0]     fwd_we,
  input  logic [5*N_FWD-1:0]   fwd_addr,
  input  logic [32*N_FWD-1:0]  fwd_data,
  input  logic [N_FWD-1:0]     fwd_pending,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_rs,
  output logic [31:0]          out_rt,
  output logic [31:0]          out_link,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {NORMAL = 1'b0, WAIT_SLOT = 1'b1} state_t;

  state_t        state_r, state_nx;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] head_r, tail_r, head_nx, tail_nx;
  logic [CW-1:0] count_r, count_nx;

  logic        kill_s, stall_s, issue_s, take_s, drop_s, enq_s, deq_s;
  logic        rs_pend_s, rt_pend_s, taken_s;
  logic [31:0] head_pc_s, head_instr_s, rs_val_s, rt_val_s, target_s;
  logic [31:0] pc4_s, br_tgt_s, j_tgt_s;
  logic [5:0]  opcode_s, funct_s;

  assign head_pc_s    = pc_mem[head_r];
  assign head_instr_s = instr_mem[head_r];
  assign opcode_s     = head_instr_s[31:26];
  assign funct_s      = head_instr_s[5:0];
  assign ra1          = head_instr_s[25:21];
  assign ra2          = head_instr_s[20:16];

  // Operand select: scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs_val_s  = (ra1 == 5'd0) ? 32'd0 : rd1;
    rt_val_s  = (ra2 == 5'd0) ? 32'd0 : rd2;
    rs_pend_s = 1'b0;
    rt_pend_s = 1'b0;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_addr[5*i +: 5] == ra1) && (ra1 != 5'd0)) begin
        rs_val_s  = fwd_data[32*i +: 32];
        rs_pend_s = fwd_pending[i];
      end else begin
        rs_val_s  = rs_val_s;
      end
      if (fwd_we[i] && (fwd_addr[5*i +: 5] == ra2) && (ra2 != 5'd0)) begin
        rt_val_s  = fwd_data[32*i +: 32];
        rt_pend_s = fwd_pending[i];
      end else begin
        rt_val_s  = rt_val_s;
      end
    end
  end

  assign pc4_s    = head_pc_s + 32'd4;
  assign br_tgt_s = pc4_s + {{14{head_instr_s[15]}}, head_instr_s[15:0], 2'b00};
  assign j_tgt_s  = {pc4_s[31:28], head_instr_s[25:0], 2'b00};

  // Branch/jump decision and target for the head instruction.
  always_comb begin
    taken_s  = 1'b0;
    target_s = br_tgt_s;
    case (opcode_s)
      6'h01: begin
        case (ra2)
          5'h00, 5'h10: taken_s = rs_val_s[31];
          5'h01, 5'h11: taken_s = ~rs_val_s[31];
          default:      taken_s = 1'b0;
        endcase
      end
      6'h02, 6'h03: begin
        taken_s  = 1'b1;
        target_s = j_tgt_s;
      end
      6'h04: taken_s = (rs_val_s == rt_val_s);
      6'h05: taken_s = (rs_val_s != rt_val_s);
      6'h06: taken_s = rs_val_s[31] | (rs_val_s == 32'd0);
      6'h07: taken_s = ~rs_val_s[31] & (rs_val_s != 32'd0);
      6'h00: begin
        if ((funct_s == 6'h08) || (funct_s == 6'h09)) begin
          taken_s  = 1'b1;
          target_s = rs_val_s;
        end else begin
          taken_s  = 1'b0;
        end
      end
      default: taken_s = 1'b0;
    endcase
  end

  assign kill_s  = reset | flush;
  assign stall_s = rs_pend_s | rt_pend_s;
  assign issue_s = out_valid & out_ready;
  assign take_s  = issue_s & taken_s;
  // A taken transfer with the delay slot already queued squashes everything younger.
  assign drop_s  = take_s & (count_r >= CW'(2));
  assign deq_s   = issue_s;
  assign enq_s   = in_valid & in_ready & ~kill_s & ~drop_s;

  assign in_ready       = (count_r < CW'(DEPTH)) | drop_s;
  assign out_valid      = (count_r != CW'(0)) & ~stall_s & ~kill_s;
  assign out_pc         = head_pc_s;
  assign out_instr      = head_instr_s;
  assign out_rs         = rs_val_s;
  assign out_rt         = rt_val_s;
  assign out_link       = head_pc_s + 32'd8;
  assign redirect_valid = take_s;
  assign redirect_pc    = target_s;

  // Pointer and occupancy update.
  always_comb begin
    head_nx  = head_r;
    tail_nx  = tail_r;
    count_nx = count_r;
    if (kill_s) begin
      head_nx  = '0;
      tail_nx  = '0;
      count_nx = '0;
    end else if (drop_s) begin
      head_nx  = head_r + PW'(1);
      tail_nx  = head_r + PW'(2);
      count_nx = CW'(1);
    end else begin
      head_nx  = head_r + PW'(deq_s);
      tail_nx  = tail_r + PW'(enq_s);
      count_nx = count_r + CW'(enq_s) - CW'(deq_s);
    end
  end

  // Delay-slot state machine next state.
  always_comb begin
    state_nx = state_r;
    if (kill_s) begin
      state_nx = NORMAL;
    end else begin
      case (state_r)
        NORMAL:    state_nx = (take_s && (count_r == CW'(1)) && !in_valid) ? WAIT_SLOT : NORMAL;
        WAIT_SLOT: state_nx = enq_s ? NORMAL : WAIT_SLOT;
        default:   state_nx = NORMAL;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= NORMAL;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_nx;
      head_r  <= head_nx;
      tail_r  <= tail_nx;
      count_r <= count_nx;
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      pc_mem[tail_r]    <= in_pc;
      instr_mem[tail_r] <= in_instr;
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: table of single-instruction operand and
// branch vectors plus hand sequences for fill, squash, delay slot, stall and flush.
module tb_decode_issue_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, redirect_valid;
  logic [31:0] in_pc, in_instr, rd1, rd2, out_pc, out_instr, out_rs, out_rt, out_link, redirect_pc;
  logic [4:0]  ra1, ra2;
  logic [2:0]  fwd_we, fwd_pending;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;

  int n_cmp = 0;
  int n_bad = 0;

  decode_issue_queue #(.DEPTH(4), .N_FWD(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs(out_rs), .out_rt(out_rt), .out_link(out_link),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, rd1, rd2;
    logic [2:0]  we;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  pend;
    logic        ev;
    logic [31:0] ers, ert;
    logic        er;
    logic [31:0] erpc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_instr = 32'd0; rd1 = 32'd0; rd2 = 32'd0;
    fwd_we = 3'd0; fwd_addr = 15'd0; fwd_data = 96'd0; fwd_pending = 3'd0;

    vecs[0]  = '{32'h100, 32'h00221821, 32'hDEAD, 32'h5, 3'b101, {5'd1, 5'd0, 5'd1},
                 {32'h22, 32'h0, 32'h11}, 3'b000, 1'b1, 32'h11, 32'h5, 1'b0, 32'h0};
    vecs[1]  = '{32'h104, 32'h00021821, 32'h77, 32'h6, 3'b001, {5'd0, 5'd0, 5'd0},
                 {32'h0, 32'h0, 32'h99}, 3'b000, 1'b1, 32'h0, 32'h6, 1'b0, 32'h0};
    vecs[2]  = '{32'h100, 32'h00221821, 32'hDEAD, 32'h5, 3'b101, {5'd1, 5'd0, 5'd1},
                 {32'h22, 32'h0, 32'h11}, 3'b100, 1'b1, 32'h11, 32'h5, 1'b0, 32'h0};
    vecs[3]  = '{32'h100, 32'h00221821, 32'hDEAD, 32'h5, 3'b101, {5'd1, 5'd0, 5'd1},
                 {32'h22, 32'h0, 32'h11}, 3'b001, 1'b0, 32'h11, 32'h5, 1'b0, 32'h0};
    vecs[4]  = '{32'h108, 32'h00221821, 32'hA, 32'hB, 3'b010, {5'd0, 5'd2, 5'd0},
                 {32'h0, 32'h33, 32'h0}, 3'b000, 1'b1, 32'hA, 32'h33, 1'b0, 32'h0};
    vecs[5]  = '{32'h200, 32'h10220004, 32'h1, 32'h2, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h1, 32'h2, 1'b0, 32'h0};
    vecs[6]  = '{32'h2000, 32'h14220004, 32'h1, 32'h2, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h1, 32'h2, 1'b1, 32'h2014};
    vecs[7]  = '{32'h3000, 32'h1820FFFE, 32'h80000000, 32'h9, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h80000000, 32'h0, 1'b1, 32'h2FFC};
    vecs[8]  = '{32'h3100, 32'h1C200003, 32'h0, 32'h0, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h0, 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{32'h4000, 32'h04310001, 32'h5, 32'h66, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h5, 32'h66, 1'b1, 32'h4008};
    vecs[10] = '{32'h4100, 32'h04200001, 32'h5, 32'h66, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h5, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{32'h5000, 32'h03E00008, 32'h12345678, 32'h99, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h12345678, 32'h0, 1'b1, 32'h12345678};
    vecs[12] = '{32'h80000010, 32'h0BFFFFFF, 32'h1, 32'h2, 3'b000, 15'd0, 96'd0, 3'b000,
                 1'b1, 32'h1, 32'h2, 1'b1, 32'h8FFFFFFC};

    // Reset state
    tick(); tick();
    reset = 1'b0;
    smp();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);

    // Fill to DEPTH, hold off a fifth, then drain
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'd0);
    smp();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_head_pc", out_pc, 32'h100);
    in_valid = 1'b1; in_pc = 32'h2222; in_instr = 32'd0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    smp();
    chk("deq_head_pc", out_pc, 32'h100);
    tick();
    out_ready = 1'b0;
    smp();
    chk("after_deq_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'h100 + 32'(4 * i));
      tick();
      smp();
    end
    chk("drained_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Taken BEQ with full queue: keep delay slot, squash the rest
    do_flush();
    push(32'h1000, 32'h10000004);
    push(32'h1004, 32'h00000000);
    push(32'h1008, 32'h00221821);
    push(32'h100C, 32'h00000000);
    smp();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h5555; in_instr = 32'd0;
    #1;
    chk("beq_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("beq_target", redirect_pc, 32'h1014);
    chk("beq_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("slot_valid", {31'd0, out_valid}, 32'd1);
    chk("slot_pc", out_pc, 32'h1004);
    chk("slot_no_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    smp();
    chk("squashed_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Load-use stall for two cycles
    do_flush();
    push(32'h600, 32'h00221821);
    fwd_we = 3'b001; fwd_addr = 15'd1; fwd_data = 96'h77; fwd_pending = 3'b001;
    rd1 = 32'hBAD; rd2 = 32'h5; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk("stall_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    fwd_pending = 3'b000;
    smp();
    chk("unstall_valid", {31'd0, out_valid}, 32'd1);
    chk("unstall_rs", out_rs, 32'h77);
    tick();
    fwd_we = 3'd0; fwd_addr = 15'd0; fwd_data = 96'd0; out_ready = 1'b0;

    // JAL alone: wait for the delay slot
    do_flush();
    push(32'h00400000, 32'h0C000010);
    out_ready = 1'b1;
    smp();
    chk("jal_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("jal_target", redirect_pc, 32'h00000040);
    chk("jal_link", out_link, 32'h00400008);
    tick();
    smp();
    chk("wait_empty", {31'd0, out_valid}, 32'd0);
    chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
    push(32'h00400004, 32'd0);
    smp();
    chk("jal_slot_pc", out_pc, 32'h00400004);
    chk("jal_slot_valid", {31'd0, out_valid}, 32'd1);
    chk("jal_slot_no_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    smp();
    chk("jal_slot_gone", {31'd0, out_valid}, 32'd0);

    // J alone with the delay slot arriving in the issue cycle
    do_flush();
    push(32'h700, 32'h08000100);
    in_valid = 1'b1; in_pc = 32'h704; in_instr = 32'd0;
    smp();
    chk("j_target", redirect_pc, 32'h400);
    chk("j_redirect", {31'd0, redirect_valid}, 32'd1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("j_slot_pc", out_pc, 32'h704);
    chk("j_slot_valid", {31'd0, out_valid}, 32'd1);
    tick();
    out_ready = 1'b0;

    // Flush suppresses issue, redirect and enqueue
    do_flush();
    push(32'h800, 32'h10000004);
    push(32'h804, 32'd0);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h900;
    smp();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    smp();
    chk("post_flush_empty", {31'd0, out_valid}, 32'd0);
    push(32'h910, 32'd0);
    smp();
    chk("post_flush_pc", out_pc, 32'h910);
    chk("post_flush_valid", {31'd0, out_valid}, 32'd1);

    // Reset mid-operation
    push(32'hA00, 32'd0);
    push(32'hA04, 32'd0);
    reset = 1'b1;
    smp();
    chk("reset_cycle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    reset = 1'b0;
    smp();
    chk("post_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-instruction operand and branch vectors
    for (int i = 0; i < 13; i++) begin
      out_ready = 1'b0;
      do_flush();
      push(vecs[i].pc, vecs[i].instr);
      rd1 = vecs[i].rd1; rd2 = vecs[i].rd2;
      fwd_we = vecs[i].we; fwd_addr = vecs[i].addr;
      fwd_data = vecs[i].data; fwd_pending = vecs[i].pend;
      out_ready = 1'b1;
      smp();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_rs", i), out_rs, vecs[i].ers);
      chk($sformatf("v%0d_rt", i), out_rt, vecs[i].ert);
      chk($sformatf("v%0d_link", i), out_link, vecs[i].pc + 32'd8);
      chk($sformatf("v%0d_redirect", i), {31'd0, redirect_valid}, {31'd0, vecs[i].er});
      if (vecs[i].er) chk($sformatf("v%0d_target", i), redirect_pc, vecs[i].erpc);
      tick();
      fwd_we = 3'd0; fwd_pending = 3'd0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
